// File: rtl/t5_led_pkg.sv
// Shared constants for the speed-LED controller: mode encodings, default
// parameters and a counter-width helper.
package t5_led_pkg;

    localparam logic [1:0] MODE_DEC   = 2'b00;
    localparam logic [1:0] MODE_BLINK = 2'b01;
    localparam logic [1:0] MODE_OFF   = 2'b10;
    localparam logic [1:0] MODE_ON    = 2'b11;

    localparam int DEF_NUM_CH      = 2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_CYCLES  = 32;
    localparam int DEF_BLINK_DIV   = 8192;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/t5_led_chan.sv
// One speed-LED channel: pin synchronisers, XNOR speed decode and a
// persistence filter that only accepts a decode held for DEB_CYCLES cycles.
module t5_led_chan
    import t5_led_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES
) (
    input  logic i_clk_32k,
    input  logic i_rst_n,
    input  logic led_a,
    input  logic led_b,
    output logic filt
);

    localparam int              CW       = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [SYNC_STAGES-1:0] sync_vld;
    logic [CW-1:0]          cnt;
    logic                   d;
    logic                   d_vld;

    // sync_vld marks when the chains hold real pin samples rather than reset
    // zeros, so power-up decode goes through the same latency as any change.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_sync   <= '0;
            b_sync   <= '0;
            sync_vld <= '0;
        end else begin
            a_sync   <= {a_sync[SYNC_STAGES-2:0], led_a};
            b_sync   <= {b_sync[SYNC_STAGES-2:0], led_b};
            sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign d     = ~(a_sync[SYNC_STAGES-1] ^ b_sync[SYNC_STAGES-1]);
    assign d_vld = sync_vld[SYNC_STAGES-1];

    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt  <= '0;
            filt <= 1'b0;
        end else if (!d_vld || d == filt) begin
            cnt  <= '0;
        end else if (cnt == CNT_LAST) begin
            filt <= d;
            cnt  <= '0;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/t5_led_spd_ctrl.sv
// N-channel port speed-LED controller: per-channel filtered decode, shared
// blink timer, per-channel mode select and a global lamp-test override.
module t5_led_spd_ctrl
    import t5_led_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
    parameter int BLINK_DIV   = DEF_BLINK_DIV
) (
    input  logic                  i_clk_32k,
    input  logic                  i_rst_n,
    input  logic [NUM_CH-1:0]     i_led_a,
    input  logic [NUM_CH-1:0]     i_led_b,
    input  logic [2*NUM_CH-1:0]   i_mode,
    input  logic                  i_lamp_test,
    output logic [NUM_CH-1:0]     o_led_spd
);

    localparam int            BW         = cnt_width(BLINK_DIV);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0]     bcnt;
    logic              blink_ph;
    logic [NUM_CH-1:0] filt;
    logic [NUM_CH-1:0] led_nxt;

    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bcnt     <= '0;
            blink_ph <= 1'b0;
        end else if (bcnt == BLINK_LAST) begin
            bcnt     <= '0;
            blink_ph <= ~blink_ph;
        end else begin
            bcnt     <= bcnt + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        t5_led_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES)
        ) u_chan (
            .i_clk_32k (i_clk_32k),
            .i_rst_n   (i_rst_n),
            .led_a     (i_led_a[k]),
            .led_b     (i_led_b[k]),
            .filt      (filt[k])
        );
    end

    // NOTE: led_nxt gets a full default before any branch so no path through
    // the block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        led_nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            case (i_mode[2*k +: 2])
                MODE_DEC:   led_nxt[k] = filt[k];
                MODE_BLINK: led_nxt[k] = filt[k] & blink_ph;
                MODE_OFF:   led_nxt[k] = 1'b0;
                MODE_ON:    led_nxt[k] = 1'b1;
            endcase
        end
        if (i_lamp_test) begin
            led_nxt = '1;
        end
    end

    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_led_spd <= '0;
        end else begin
            o_led_spd <= led_nxt;
        end
    end

endmodule
